// File: rtl/chebyshev_computation.sv
// Weighted second-order Chebyshev term: data_out = coeff_in * (2*data_in^2 - 1), fixed point.
// Latency 3 clocks, one sample per clock, no backpressure: the pipeline never stalls.
module chebyshev_computation #(
  parameter  int WL       = 4,
  parameter  int CL       = 4,
  parameter  int WIDENING = 0,
  localparam int OW       = 2*WL + CL + WIDENING
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic signed [WL-1:0] data_in,
  input  logic signed [CL-1:0] coeff_in,
  output logic signed [OW-1:0] data_out
);

  // 1.0 in the Q2.(2WL-2) square format, widened by one bit for the doubled square
  localparam logic signed [2*WL:0] ONE_SQ = (2*WL+1)'(2**(2*WL-2));

  logic signed [WL-1:0]   x_reg;
  logic signed [CL-1:0]   c_reg;
  logic signed [CL-1:0]   c_dly;
  logic signed [2*WL-1:0] t2_reg;

  logic signed [2*WL-1:0] x_ext;
  logic signed [2*WL-1:0] sq;
  logic signed [2*WL:0]   t2_full;
  logic signed [2*WL-1:0] t2;
  logic signed [OW-1:0]   t2_ext;
  logic signed [OW-1:0]   c_ext;
  logic signed [OW-1:0]   prod;

  // x^2 is at most 1.0 (x = -1), so 2WL bits hold it without overflow
  always_comb begin
    x_ext   = (2*WL)'(x_reg);
    sq      = x_ext * x_ext;
    t2_full = {sq, 1'b0} - ONE_SQ;
    t2      = t2_full[2*WL-1:0];
  end

  // Operands are sign-extended to OW first so the product is exact and already widened
  always_comb begin
    t2_ext = OW'(t2_reg);
    c_ext  = OW'(c_dly);
    prod   = t2_ext * c_ext;
  end

  always_ff @(posedge clock) begin
    if (resetn) begin
      x_reg    <= '0;
      c_reg    <= '0;
      t2_reg   <= '0;
      c_dly    <= '0;
      data_out <= '0;
    end else begin
      x_reg    <= data_in;
      c_reg    <= coeff_in;
      t2_reg   <= t2;
      c_dly    <= c_reg;
      data_out <= prod;
    end
  end

  // T2 lies in [-1, 1], so dropping the top bit of t2_full never loses information
  a_t2_lossless: assert property (@(posedge clock) disable iff (resetn)
    t2_full[2*WL] == t2_full[2*WL-1]);

endmodule

// File: tb/tb_chebyshev_computation.sv
// Directed bench for chebyshev_computation (WL=4, CL=4): literal checks per vector plus
// a per-cycle comparison against an integer model of c*(2x^2-1) delayed by the pipeline depth.
module tb_chebyshev_computation;

  logic              clock;
  logic              resetn;
  logic signed [3:0] data_in;
  logic signed [3:0] coeff_in;
  logic signed [11:0] data_out;

  int n_checks = 0;
  int n_pass   = 0;

  chebyshev_computation #(.WL(4), .CL(4), .WIDENING(0)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .data_in  (data_in),
    .coeff_in (coeff_in),
    .data_out (data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // c*T2(x) in units of 2^-8: x = xi/8, c = ci/4, so c*(2x^2-1)*256 = ci*(2*xi*xi - 64)
  function automatic int term(input logic [3:0] x, input logic [3:0] c);
    int xi;
    int ci;
    xi = int'($signed(x));
    ci = int'($signed(c));
    return ci * (2*xi*xi - 64);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: data_out=%0d (0x%03h) expected %0d (0x%03h)",
                  name, act, act[11:0], exp, exp[11:0]);
  endtask

  // Model: result of an input is visible after the third edge counting its capture edge;
  // a reset edge clears everything in flight.
  int  dly[3];
  bit  model_ok = 1'b0;

  always @(posedge clock) begin
    if (resetn) begin
      dly      = '{0, 0, 0};
      model_ok = 1'b1;
    end else begin
      dly[2] = dly[1];
      dly[1] = dly[0];
      dly[0] = term(data_in, coeff_in);
    end
  end

  always @(negedge clock) begin
    if (model_ok) check("model", int'(data_out), dly[2]);
  end

  task automatic drive(input logic [3:0] x, input logic [3:0] c, input logic r);
    data_in  = x;
    coeff_in = c;
    resetn   = r;
    @(posedge clock);
    #1;
  endtask

  localparam int NV = 16;
  logic [3:0] vx [NV] = '{4'h3, 4'hA, 4'h4, 4'h1, 4'h7, 4'h8, 4'h0, 4'h4,
                          4'h4, 4'h5, 4'h1, 4'h7, 4'h2, 4'h0, 4'h0, 4'h0};
  logic [3:0] vc [NV] = '{4'h9, 4'h5, 4'h2, 4'h5, 4'h0, 4'h7, 4'h8, 4'h2,
                          4'h2, 4'h5, 4'h5, 4'h3, 4'h6, 4'h0, 4'h0, 4'h0};
  logic       vr [NV] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                          1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  // Expected data_out just after each edge, hand-computed (LSB = 2^-8)
  logic [11:0] ve [NV] = '{12'h000, 12'h000, 12'h000, 12'h000, 12'hFC0, 12'hECA,
                           12'h000, 12'h1C0, 12'h200, 12'h000, 12'h000, 12'h000,
                           12'hECA, 12'h066, 12'hEB0, 12'h000};

  initial begin
    data_in  = 4'h0;
    coeff_in = 4'h0;
    resetn   = 1'b1;
    for (int i = 0; i < NV; i++) begin
      logic [11:0] e;
      drive(vx[i], vc[i], vr[i]);
      e = ve[i];
      check($sformatf("vec%0d", i), int'(data_out), int'($signed(e)));
    end
    for (int i = 0; i < 40; i++) begin
      drive(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 19) == 0));
    end
    drive(4'h0, 4'h0, 1'b0);
    @(negedge clock);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/chebyshev_computation.md
Name: chebyshev_computation

Overview:
- Fixed-point pipelined datapath that evaluates one weighted second-order Chebyshev term, data_out = coeff_in * T2(data_in), where T2(x) = 2x^2 - 1.
- Free-running, one result per clock, no handshake.
- Used as the per-sample term evaluator inside the Chebyshev polynomial approximation chain. Coefficients come from a coefficient store and results go to a downstream accumulator.

Parameters:
- WL, 4: word length of data_in. Signed Q1.(WL-1), range [-1, 1).
- CL, 4: word length of coeff_in. Signed Q2.(CL-2), range [-2, 2).
- WIDENING, 0: extra guard bits added to the MSB side of data_out (sign-extended).
- Derived localparam OW = 2*WL + CL + WIDENING.

Ports:
- clock, input, 1: single clock. All state updates on the rising edge.
- resetn, input, 1: synchronous, active-high reset. The name follows the codebase; the polarity is active-high despite the suffix.
- data_in, input, WL: signed x, Q1.(WL-1).
- coeff_in, input, CL: signed c, Q2.(CL-2).
- data_out, output, OW: signed c*T2(x), registered, Q(4+WIDENING).(2WL+CL-4).

Behaviour:
- Reset:
  - resetn=1 at a rising edge clears every pipeline register (x_reg, c_reg, t2_reg, c_dly, data_out) to 0.
  - Reset dominates any data captured on the same edge.
  - Reset asserted mid-stream discards all in-flight values. After release, data_out stays 0 until the first post-reset sample emerges.
- Pipeline, latency 3 edges from input capture to data_out:
  - Stage 1: x_reg <= data_in; c_reg <= coeff_in.
  - Stage 2, square: form sq = x_reg*x_reg as a signed 2WL-bit value, Q2.(2WL-2).
  - Stage 2, T2: compute t2 = (sq <<< 1) - 2^(2WL-2) in 2WL+1 bits, then truncate to 2WL bits. The result always lies in [-1, 1], so the truncation is lossless.
  - Stage 2, registers: t2_reg <= t2; c_dly <= c_reg.
  - Stage 3: data_out <= sign_extend(t2_reg * c_dly, OW). The product is a full-precision signed 2WL+CL bit value with 2WL+CL-4 fraction bits.
- Throughput: a new sample is accepted every clock. Pipeline registers have no enable and are never stalled.
- Arithmetic rules:
  - All multiplies are signed, full precision.
  - No rounding and no saturation is needed anywhere; the result range is |c*T2| <= 2.
- Boundary cases:
  - x = -1 (most negative): x^2 = 1, T2 = +1. This must be representable with no overflow.
  - x = 0: T2 = -1.
  - c = -2 with T2 = -1: data_out = +2. This fits because the integer field is 4 bits wide.
  - WIDENING > 0 only sign-extends; it never changes the value.
- Output holds the last registered value. It is undefined only for reset-free simulation time before the first edge.

Test Plan (WL=4, CL=4, WIDENING=0, OW=12; LSB = 2^-8):
- Reset: hold resetn=1 for 2 edges with arbitrary inputs -> data_out = 12'h000; it stays 0 for the first 2 edges after release.
- x=4'b0100 (0.5), c=4'b0010 (0.5) -> T2=-0.5; 3 edges later data_out = -0.25 = 12'hFC0.
- x=4'b0001 (0.125), c=4'b0101 (1.25) -> T2=-0.96875; data_out = -310 = 12'hECA, 3 edges after capture.
- x=4'b0111 (0.875), c=4'b0000 -> data_out = 12'h000. Apply back-to-back with the previous two vectors and check each result lands in consecutive cycles (full throughput).
- Extremes:
  - x=4'b1000 (-1), c=4'b0111 (1.75) -> T2=+1, data_out = 448 = 12'h1C0.
  - x=4'b0000, c=4'b1000 (-2) -> T2=-1, data_out = +512 = 12'h200.
- Mid-stream reset: assert resetn for 1 edge while the pipeline is full -> data_out 0 on the next edge; all in-flight results are lost and valid results resume 3 edges after new input.
